// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared constants and width helper for the decoder/sequencer
// Contents:
//   MODO_DIRECTO / MODO_PASO : encodings of the modo input
//   ancho_sal(n)             : one-hot output width, 2**n
package dec_pkg;

  localparam logic MODO_DIRECTO = 1'b0;
  localparam logic MODO_PASO    = 1'b1;

  function automatic int ancho_sal(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/decodificador_n.sv
// rtl/decodificador_n.sv - combinational N-to-2**N one-hot decoder with enable
// Ports:
//   ent : N-bit select value
//   ena : when 0 the output is all-zero
//   sal : 2**N-bit one-hot decode of ent
module decodificador_n
  import dec_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]              ent,
  input  logic                      ena,
  output logic [ancho_sal(N)-1:0]   sal
);

  always_comb begin
    sal = '0;
    if (ena) begin
      sal[ent] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_secuenciador.sv
// rtl/dec_secuenciador.sv - registered one-hot decoder / stepping sequencer
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   ena        : enable; 0 holds the state and forces sal to zero
//   modo       : MODO_DIRECTO registers a decode of ent, MODO_PASO steps the state
//   carga      : synchronous load of ent into the state (highest priority)
//   ent        : select value (DIRECTO) or load value (carga)
//   ultimo     : last state of the PASO sequence
//   sal        : registered one-hot decode of the state
//   estado     : current state
//   fin        : one-cycle pulse after a PASO wrap at ultimo
module dec_secuenciador
  import dec_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      modo,
  input  logic                      carga,
  input  logic [N-1:0]              ent,
  input  logic [N-1:0]              ultimo,
  output logic [ancho_sal(N)-1:0]   sal,
  output logic [N-1:0]              estado,
  output logic                      fin
);

  localparam logic [N-1:0] TODO_UNOS = {N{1'b1}};

  logic [N-1:0]            estado_sig;
  logic                    fin_sig;
  logic [ancho_sal(N)-1:0] sal_sig;

  // Next-state priority: carga, then hold when disabled, then mode.
  // The ultimo comparison comes before the all-ones test so that
  // ultimo == all-ones still produces a fin pulse on its wrap.
  always_comb begin
    estado_sig = estado;
    fin_sig    = 1'b0;
    if (carga) begin
      estado_sig = ent;
    end else if (!ena) begin
      estado_sig = estado;
    end else if (modo == MODO_DIRECTO) begin
      estado_sig = ent;
    end else if (estado == ultimo) begin
      estado_sig = '0;
      fin_sig    = 1'b1;
    end else if (estado == TODO_UNOS) begin
      estado_sig = '0;
    end else begin
      estado_sig = estado + 1'b1;
    end
  end

  // Decode the next state so sal and estado change on the same edge.
  decodificador_n #(.N(N)) u_dec (
    .ent (estado_sig),
    .ena (ena),
    .sal (sal_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= '0;
      fin    <= 1'b0;
      sal    <= '0;
    end else begin
      estado <= estado_sig;
      fin    <= fin_sig;
      sal    <= sal_sig;
    end
  end

endmodule

// File: doc/dec_secuenciador.md
DEC_SECUENCIADOR -- requirements
Module: dec_secuenciador

Interface
REQ-001 Parameter N, default 3, width of the state/select field; output width is 2**N; legal range 1..6.
REQ-002 Port clk  input  1  single rising-edge clock for all state.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port ena  input  1  enable; 0 freezes state and forces sal to zero.
REQ-005 Port modo  input  1  0 = DIRECTO (registered decoder of ent), 1 = PASO (one-hot stepping sequencer).
REQ-006 Port carga  input  1  synchronous load of ent into state, any mode.
REQ-007 Port ent  input  N  select value (DIRECTO) or load value (carga).
REQ-008 Port ultimo  input  N  last state of the PASO sequence; the sequence wraps to 0 after it.
REQ-009 Port sal  output  2**N  registered one-hot decode of the state, all-zero when disabled.
REQ-010 Port estado  output  N  current state register.
REQ-011 Port fin  output  1  registered one-cycle pulse on PASO wrap at ultimo.

Function
REQ-012 Per rising edge, next-state priority: carga=1 -> estado<=ent; else ena=0 -> hold; else modo=0 -> estado<=ent; else PASO step.
REQ-013 PASO step: if estado==ultimo then estado<=0 and fin<=1; else if estado==all-ones then estado<=0 with fin<=0; else estado<=estado+1.
REQ-014 fin SHALL be 1 for exactly the cycle following the wrap edge and 0 in every other cycle, including load and DIRECTO cycles.
REQ-015 sal SHALL update on the same edge as estado: sal <= ena ? (1 << next estado) : 0, so sal is always consistent with estado one cycle after input changes (latency 1).
REQ-016 carga with ena=0: estado SHALL load, and sal SHALL be all-zero.
REQ-017 Simultaneous carga and a PASO wrap condition: carga wins; fin SHALL stay 0.
REQ-018 ent loaded above ultimo in PASO: the state counts up to all-ones, wraps to 0 without fin, then follows the normal sequence.
REQ-019 ultimo==0 in PASO: estado SHALL stay at 0 and fin SHALL pulse every enabled cycle.
REQ-020 modo changing mid-sequence takes effect on the next edge, with no extra pipeline stage.
REQ-021 sal SHALL never have more than one bit set.

Reset
REQ-022 rst_n low SHALL immediately force estado=0, sal=0, and fin=0, independent of clk.
REQ-023 Release of rst_n SHALL be synchronised by the user, and the first active edge after release follows REQ-012 normally.
REQ-024 Reset asserted mid-sequence SHALL abandon the sequence, and no fin SHALL be produced for it.

Structure
REQ-025 Shared package dec_pkg SHALL hold the constants MODO_DIRECTO=1'b0 and MODO_PASO=1'b1 and the function for the output width 2**N.
REQ-026 One combinational sub-module, decodificador_n (parameter N, inputs ent and ena, output sal), SHALL generate the one-hot vector, generalising the existing 3-bit decoder.
REQ-027 Sequential logic (state register, fin, sal register) SHALL live only in dec_secuenciador, and the block SHALL be fully synthesisable with no latches.

Verification (N=3 unless stated)
REQ-028 Reset: rst_n=0 mid-clock -> estado=0, sal=8'h00, fin=0 without waiting for an edge.
REQ-029 DIRECTO: ena=1, modo=0, ent=0..7 one per cycle -> sal=8'h01,02,04,...,80 one cycle later; with ena=0 and ent=5 -> sal=8'h00 and estado held.
REQ-030 PASO: ultimo=4, ena=1 from estado 0 -> estado 0,1,2,3,4,0; sal 01,02,04,08,10,01; fin high only in the cycle after the 4->0 edge.
REQ-031 Load and overflow: carga=1, ent=6, ultimo=4, then PASO -> estado 6,7,0,1 with fin=0 throughout that wrap.
REQ-032 Corners: carga at the wrap cycle gives fin=0; ultimo=0 gives fin high every cycle; N=1 and N=5 builds give sal widths 2 and 32, with the one-hot check asserted every cycle.
